// File: rtl/boson_video_gen.sv
// Boson-style CMOS video source: pixel-rate divider, raster counters, frame-aligned
// start/stop, selectable test patterns, frame counter and frame-start strobe.
module boson_video_gen #(
  parameter int DATA_WIDTH  = 16,
  parameter int H_TOTAL     = 1711,
  parameter int V_TOTAL     = 263,
  parameter int V_BLANK     = 7,
  parameter int H_SYNC_LEN  = 7,
  parameter int H_ACT_START = 693,
  parameter int H_ACTIVE    = 319,
  parameter int CLK_DIV     = 1,
  parameter int CHK_SHIFT   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] const_value,
  output logic [DATA_WIDTH-1:0] CMOS_DQ,
  output logic                  CMOS_VSYNC,
  output logic                  CMOS_HSYNC,
  output logic                  CMOS_VALID,
  output logic                  pix_tick,
  output logic                  frame_start,
  output logic [15:0]           frame_count
);

  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC   = HW'(H_SYNC_LEN);
  localparam logic [HW-1:0] H_START  = HW'(H_ACT_START);
  localparam logic [HW-1:0] H_END    = HW'(H_ACT_START + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_BLANK);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state;
  logic [DW-1:0]           div_cnt;
  logic [HW-1:0]           h_cnt;
  logic [VW-1:0]           v_cnt;
  logic [DATA_WIDTH-1:0]   pix_cnt;
  logic [1:0]              mode_q;
  logic [DATA_WIDTH-1:0]   const_q;

  logic                    tick_p0, boundary_p0, run_p0;
  logic                    vsync_p0, hsync_p0, valid_p0;
  logic [1:0]              mode_p0;
  logic [DATA_WIDTH-1:0]   cval_p0, pix_next_p0;
  logic [HW-1:0]           x_p0;
  logic [VW-1:0]           y_p0;

  function automatic logic chk_bit(input logic [HW-1:0] x, input logic [VW-1:0] y);
    logic xb, yb;
    xb = |((x >> CHK_SHIFT) & HW'(1));
    yb = |((y >> CHK_SHIFT) & VW'(1));
    chk_bit = xb ^ yb;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [1:0]            sel,
    input logic [HW-1:0]         x,
    input logic [VW-1:0]         y,
    input logic [DATA_WIDTH-1:0] pix,
    input logic [DATA_WIDTH-1:0] cval
  );
    case (sel)
      2'd0:    pattern = pix;
      2'd1:    pattern = DATA_WIDTH'(x);
      2'd2:    pattern = chk_bit(x, y) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
      default: pattern = cval;
    endcase
  endfunction

  // Stage p0: decode of the current raster position, consumed on the tick
  always_comb begin
    tick_p0     = (div_cnt == DIV_LAST);
    boundary_p0 = tick_p0 && (h_cnt == '0) && (v_cnt == '0);
    // A boundary decides whether the new frame exists at all; otherwise keep the current state.
    run_p0      = boundary_p0 ? enable : (state == RUN);
    mode_p0     = (boundary_p0 && enable) ? mode : mode_q;
    cval_p0     = (boundary_p0 && enable) ? const_value : const_q;
    pix_next_p0 = (boundary_p0 ? '0 : pix_cnt) + DATA_WIDTH'(1);
    vsync_p0    = run_p0 && (v_cnt >= V_ACT);
    hsync_p0    = vsync_p0 && (h_cnt >= H_SYNC);
    valid_p0    = vsync_p0 && (h_cnt >= H_START) && (h_cnt < H_END);
    x_p0        = h_cnt - H_START;
    y_p0        = v_cnt - V_ACT;
  end

  // Stage p1: registered counters, control and video outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_cnt     <= '0;
      mode_q      <= '0;
      const_q     <= '0;
      frame_count <= '0;
      frame_start <= 1'b0;
      pix_tick    <= 1'b0;
      CMOS_DQ     <= '0;
      CMOS_VSYNC  <= 1'b0;
      CMOS_HSYNC  <= 1'b0;
      CMOS_VALID  <= 1'b0;
    end else begin
      pix_tick    <= tick_p0;
      frame_start <= 1'b0;
      div_cnt     <= tick_p0 ? '0 : div_cnt + DW'(1);
      if (tick_p0) begin
        if (boundary_p0) begin
          if (enable) begin
            state       <= RUN;
            mode_q      <= mode;
            const_q     <= const_value;
            frame_start <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end else begin
            state <= IDLE;
          end
        end
        if (run_p0) begin
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
          end else begin
            h_cnt <= h_cnt + HW'(1);
          end
        end else begin
          h_cnt <= '0;
          v_cnt <= '0;
        end
        CMOS_VSYNC <= vsync_p0;
        CMOS_HSYNC <= hsync_p0;
        CMOS_VALID <= valid_p0;
        CMOS_DQ    <= valid_p0 ? pattern(mode_p0, x_p0, y_p0, pix_next_p0, cval_p0) : '0;
        if (valid_p0)
          pix_cnt <= pix_next_p0;
        else if (boundary_p0)
          pix_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_boson_video_gen.sv
// Scoreboard bench for boson_video_gen: three instances cover small-raster patterns,
// a divided pixel clock, and frame counter wrap on a one-tick frame.
`timescale 1ns/1ps
module tb_boson_video_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    n_chk++;
    $display("FAIL %s: got 0x%0h, expected no output", name, act);
  endtask

  // Instance A: small raster, CLK_DIV=1, CHK_SHIFT=1
  logic        rst_a = 1'b1, en_a = 1'b0;
  logic [1:0]  mode_a = 2'd0;
  logic [15:0] cv_a = 16'h0;
  logic [15:0] dq_a, fc_a;
  logic        vs_a, hs_a, va_a, pt_a, fs_a;

  boson_video_gen #(
    .DATA_WIDTH(16), .H_TOTAL(20), .V_TOTAL(6), .V_BLANK(2), .H_SYNC_LEN(2),
    .H_ACT_START(5), .H_ACTIVE(8), .CLK_DIV(1), .CHK_SHIFT(1)
  ) dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .mode(mode_a), .const_value(cv_a),
    .CMOS_DQ(dq_a), .CMOS_VSYNC(vs_a), .CMOS_HSYNC(hs_a), .CMOS_VALID(va_a),
    .pix_tick(pt_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  // Instance B: same raster, CLK_DIV=3
  logic        rst_b = 1'b1, en_b = 1'b0;
  logic [1:0]  mode_b = 2'd3;
  logic [15:0] cv_b = 16'hA5A5;
  logic [15:0] dq_b, fc_b;
  logic        vs_b, hs_b, va_b, pt_b, fs_b;

  boson_video_gen #(
    .DATA_WIDTH(16), .H_TOTAL(20), .V_TOTAL(6), .V_BLANK(2), .H_SYNC_LEN(2),
    .H_ACT_START(5), .H_ACTIVE(8), .CLK_DIV(3), .CHK_SHIFT(1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .mode(mode_b), .const_value(cv_b),
    .CMOS_DQ(dq_b), .CMOS_VSYNC(vs_b), .CMOS_HSYNC(hs_b), .CMOS_VALID(va_b),
    .pix_tick(pt_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  // Instance C: one tick per frame, so the frame counter wraps quickly
  logic        rst_c = 1'b1, en_c = 1'b0;
  logic [1:0]  mode_c = 2'd0;
  logic [15:0] cv_c = 16'h0;
  logic [15:0] dq_c, fc_c;
  logic        vs_c, hs_c, va_c, pt_c, fs_c;

  boson_video_gen #(
    .DATA_WIDTH(16), .H_TOTAL(1), .V_TOTAL(1), .V_BLANK(1), .H_SYNC_LEN(1),
    .H_ACT_START(1), .H_ACTIVE(0), .CLK_DIV(1), .CHK_SHIFT(3)
  ) dut_c (
    .clk(clk), .reset(rst_c), .enable(en_c), .mode(mode_c), .const_value(cv_c),
    .CMOS_DQ(dq_c), .CMOS_VSYNC(vs_c), .CMOS_HSYNC(hs_c), .CMOS_VALID(va_c),
    .pix_tick(pt_c), .frame_start(fs_c), .frame_count(fc_c)
  );

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic        a_on = 1'b0, b_on = 1'b0;

  // Monitor A: every valid pixel pops the scoreboard; DQ must be 0 otherwise
  always @(negedge clk) begin
    if (a_on) begin
      if (va_a) begin
        if (qa.size() == 0) fail("a_extra_pixel", 32'(dq_a));
        else check("a_pixel", 32'(dq_a), 32'(qa.pop_front()));
      end else begin
        check("a_dq_when_invalid", 32'(dq_a), 0);
      end
    end
  end

  // Monitor B: tick period, hold between ticks, one pixel per valid tick
  int          last_pt = -1;
  logic [15:0] prev_dq_b = 16'h0;
  logic [2:0]  prev_sync_b = 3'b0;
  always @(negedge clk) begin
    if (b_on) begin
      if (pt_b) begin
        if (last_pt >= 0) check("b_tick_period", cyc - last_pt, 3);
        last_pt <= cyc;
        if (va_b) begin
          if (qb.size() == 0) fail("b_extra_pixel", 32'(dq_b));
          else check("b_pixel", 32'(dq_b), 32'(qb.pop_front()));
        end
      end else begin
        check("b_hold_dq", 32'(dq_b), 32'(prev_dq_b));
        check("b_hold_sync", 32'({vs_b, hs_b, va_b}), 32'(prev_sync_b));
      end
      prev_dq_b   <= dq_b;
      prev_sync_b <= {vs_b, hs_b, va_b};
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs_a(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (fs_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_va_a(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (va_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic push_count_a();
    for (int i = 1; i <= 32; i++) qa.push_back(16'(i));
  endtask

  task automatic run_a();
    bit ok, seen;
    int t0;
    logic [7:0] cb_row;
    step(3);
    check("a_rst_dq", 32'(dq_a), 0);
    check("a_rst_ctrl", 32'({vs_a, hs_a, va_a, pt_a, fs_a}), 0);
    check("a_rst_fc", 32'(fc_a), 0);
    rst_a = 1'b0;
    a_on  = 1'b1;

    // Frame 1: running counter, 1..32
    mode_a = 2'd0;
    en_a   = 1'b1;
    push_count_a();
    wait_fs_a(10, ok);
    check("a_fs1_seen", 32'(ok), 1);
    t0 = cyc;
    check("a_fc1", 32'(fc_a), 1);
    step(39);
    check("a_k39_vsync", 32'(vs_a), 0);
    step(1);
    check("a_k40_sync", 32'({vs_a, hs_a, va_a}), 'b100);
    step(2);
    check("a_k42_sync", 32'({vs_a, hs_a, va_a}), 'b110);
    step(3);
    check("a_k45_sync", 32'({vs_a, hs_a, va_a}), 'b111);
    step(5);
    mode_a = 2'd1;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) qa.push_back(16'(x));
    step(3);
    check("a_k53_sync", 32'({vs_a, hs_a, va_a}), 'b110);

    // Frame 2: x ramp; a short enable drop mid-frame must be ignored
    wait_fs_a(200, ok);
    check("a_fs2_seen", 32'(ok), 1);
    check("a_frame_period", cyc - t0, 120);
    check("a_fc2", 32'(fc_a), 2);
    mode_a = 2'd2;
    for (int y = 0; y < 4; y++) begin
      cb_row = (y < 2) ? 8'b1100_1100 : 8'b0011_0011;
      for (int x = 0; x < 8; x++) qa.push_back(cb_row[x] ? 16'hFFFF : 16'h0000);
    end
    step(10);
    en_a = 1'b0;
    step(3);
    en_a = 1'b1;

    // Frame 3: checkerboard
    wait_fs_a(200, ok);
    check("a_fs3_seen", 32'(ok), 1);
    check("a_fc3", 32'(fc_a), 3);
    mode_a = 2'd3;
    cv_a   = 16'h1234;
    for (int i = 0; i < 32; i++) qa.push_back(16'h1234);

    // Frame 4: constant; mid-frame changes and stop request must not disturb it
    wait_fs_a(200, ok);
    check("a_fs4_seen", 32'(ok), 1);
    check("a_fc4", 32'(fc_a), 4);
    cv_a   = 16'h9999;
    mode_a = 2'd0;
    en_a   = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (fs_a) seen = 1'b1;
    end
    check("a_no_restart", 32'(seen), 0);
    check("a_fc_hold", 32'(fc_a), 4);
    check("a_drain_stop", qa.size(), 0);

    // Frame 5 aborted by reset mid-line
    en_a = 1'b1;
    push_count_a();
    wait_fs_a(10, ok);
    check("a_fs5_seen", 32'(ok), 1);
    check("a_fc5", 32'(fc_a), 5);
    wait_va_a(100, ok);
    check("a_va5_seen", 32'(ok), 1);
    step(3);
    rst_a = 1'b1;
    en_a  = 1'b0;
    step(1);
    check("a_midrst_dq", 32'(dq_a), 0);
    check("a_midrst_ctrl", 32'({vs_a, hs_a, va_a, pt_a, fs_a}), 0);
    check("a_midrst_fc", 32'(fc_a), 0);
    qa.delete();
    rst_a = 1'b0;
    en_a  = 1'b1;
    push_count_a();
    wait_fs_a(10, ok);
    check("a_fs_after_rst", 32'(ok), 1);
    check("a_fc_after_rst", 32'(fc_a), 1);
    t0 = cyc;
    en_a = 1'b0;
    wait_va_a(100, ok);
    check("a_va_after_rst", 32'(ok), 1);
    check("a_first_pix_latency", cyc - t0, 45);
    step(200);
    check("a_drain_end", qa.size(), 0);
    a_on = 1'b0;
  endtask

  task automatic run_b();
    bit ok;
    step(3);
    rst_b = 1'b0;
    step(1);
    b_on = 1'b1;
    en_b = 1'b1;
    for (int i = 0; i < 32; i++) qb.push_back(16'hA5A5);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fs_b) begin ok = 1'b1; break; end
    end
    check("b_fs_seen", 32'(ok), 1);
    check("b_fc1", 32'(fc_b), 1);
    en_b = 1'b0;
    step(400);
    check("b_drain", qb.size(), 0);
    check("b_fc_hold", 32'(fc_b), 1);
    b_on = 1'b0;
  endtask

  task automatic run_c();
    bit ok;
    int t0;
    step(3);
    rst_c = 1'b0;
    en_c  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fs_c) begin ok = 1'b1; break; end
    end
    check("c_fs_seen", 32'(ok), 1);
    check("c_fc1", 32'(fc_c), 1);
    t0 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (fc_c == 16'hFFFF) begin ok = 1'b1; break; end
    end
    check("c_reach_ffff", 32'(ok), 1);
    check("c_ffff_cycles", cyc - t0, 65534);
    step(1);
    check("c_wrap_zero", 32'({fs_c, fc_c}), 'h10000);
    en_c = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      run_a();
      run_b();
      run_c();
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/boson_video_gen.md
Name: boson_video_gen

Overview:
- Synthesizable, parametrised Boson-style CMOS video source.
- Produces the DQ/VSYNC/HSYNC/VALID stream the capture path consumes, on the system clock with a programmable pixel-rate divider.
- Adds selectable test patterns, frame-aligned start/stop, a frame counter and a frame-start strobe.
- Used in on-chip loopback self-test and in simulation in place of a free-running camera model.

Parameters:
- DATA_WIDTH, 16, pixel bus width.
- H_TOTAL, 1711, pixel ticks per line including blanking.
- V_TOTAL, 263, lines per frame including blanking.
- V_BLANK, 7, leading lines per frame with VSYNC low.
- H_SYNC_LEN, 7, leading ticks per active line with HSYNC low.
- H_ACT_START, 693, first tick index of valid pixels in a line.
- H_ACTIVE, 319, valid pixels per line; H_ACT_START+H_ACTIVE must be <= H_TOTAL.
- CLK_DIV, 1, system clocks per pixel tick (>=1).
- CHK_SHIFT, 3, log2 of checkerboard square size.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  request streaming; sampled only at frame boundary
- mode  in  2  pattern select; latched at frame boundary
- const_value  in  DATA_WIDTH  pixel value for mode 3; latched at frame boundary
- CMOS_DQ  out  DATA_WIDTH  pixel data; 0 when CMOS_VALID=0
- CMOS_VSYNC  out  1  high during active lines
- CMOS_HSYNC  out  1  low for sync period of each active line
- CMOS_VALID  out  1  pixel qualifier
- pix_tick  out  1  one-cycle strobe, pixel-rate timing reference
- frame_start  out  1  one-cycle pulse at first tick of each streamed frame
- frame_count  out  16  frames started since reset; wraps at 0xFFFF->0

Behaviour:
- Reset: all outputs, h_cnt, v_cnt, div_cnt, pixel counter, frame_count and running cleared to 0; mode/const latches cleared to 0. Reset mid-frame aborts immediately with no partial-line completion.
- Divider: div_cnt counts 0..CLK_DIV-1. Internal tick asserts when div_cnt==CLK_DIV-1. CLK_DIV=1 gives a tick every cycle. pix_tick is the registered tick.
- Counters advance only on tick:
  - h_cnt 0..H_TOTAL-1, then wraps to 0 and increments v_cnt.
  - v_cnt 0..V_TOTAL-1, then wraps to 0.
- Frame boundary: tick with h_cnt==0 and v_cnt==0.
- State IDLE: counters held at 0, all video outputs 0. At a boundary tick with enable=1:
  - go RUN;
  - latch mode and const_value;
  - clear pixel counter;
  - pulse frame_start;
  - increment frame_count.
- State RUN: counters free-run.
  - At each boundary tick: if enable=1, re-latch mode/const_value, pulse frame_start, increment frame_count.
  - If enable=0 at a boundary tick, return to IDLE; the frame in progress always completes.
- Video decode, registered, updated one cycle after the tick that sets h_cnt/v_cnt (latency 1 clk); outputs hold between ticks:
  - CMOS_VSYNC = v_cnt>=V_BLANK.
  - CMOS_HSYNC = VSYNC && h_cnt>=H_SYNC_LEN; 0 during vblank.
  - CMOS_VALID = VSYNC && H_ACT_START<=h_cnt<H_ACT_START+H_ACTIVE.
- Pattern, with x = h_cnt-H_ACT_START and y = v_cnt-V_BLANK:
  - mode 0: running pixel counter. Increments before output on each valid tick, so first pixel of frame = 1. Continues across lines, wraps modulo 2^DATA_WIDTH, cleared at each frame boundary.
  - mode 1: x, truncated to DATA_WIDTH.
  - mode 2: all-ones if bit0 of ((x>>CHK_SHIFT) ^ (y>>CHK_SHIFT)) is 1, else 0.
  - mode 3: latched const_value.
- Simultaneous events:
  - reset has priority over everything.
  - A mode/const_value change mid-frame has no effect until the next boundary.
  - enable pulses that do not span a boundary tick are ignored.

Test Plan:
- Small params H_TOTAL=20, V_TOTAL=6, V_BLANK=2, H_SYNC_LEN=2, H_ACT_START=5, H_ACTIVE=8, CLK_DIV=1, mode 0, enable=1 -> 4 active lines of 8 valid pixels each; DQ 1..32 in order; DQ=0 whenever VALID=0; HSYNC low for ticks 0-1 of active lines; frame_start once per 120 clocks; frame_count=1 then 2.
- Same params, mode 1 -> each active line DQ 0..7. Mode 2 with CHK_SHIFT=1 -> line 0 pattern 0,0,F..,F..,0,0,F..,F.. and line 2 inverted.
- CLK_DIV=3, mode 3, const_value=0xA5A5 -> pix_tick every 3rd clk; outputs stable for 3 clks; every valid pixel = 0xA5A5.
- Deassert enable mid-frame 1 and change mode mid-frame -> frame 1 completes with the original pattern; then all outputs 0; frame_count stays 1; no frame_start pulse.
- Assert reset mid-line with VALID=1 -> next cycle all outputs 0 and frame_count=0. Re-enable -> first VALID pixel = 1 after exactly V_BLANK*H_TOTAL+H_ACT_START+1 ticks from the boundary.
- Run 65536 frames (or force frame_count to 0xFFFF) -> next frame_start wraps frame_count to 0.
